// File: rtl/uart_pkg.sv
// UART receive shared types.
// Frame-controller state encoding and data width.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

endpackage

// File: rtl/parity_checker.sv
// Even-parity checker.
// High when data and parity bit disagree.
module parity_checker (
  output logic       parity_error,
  input  logic       parity_in,
  input  logic [7:0] data_in
);

  assign parity_error = (^data_in) ^ parity_in;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Oversampled start/data/parity/stop capture.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]    BIT_MAX = 3'(DATA_BITS - 1);

  state_e state_q, state_d;

  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 valid_q, valid_d;
  logic                 chk_err;
  logic                 cnt_wrap;

  assign rx_s = sync2_q;

  parity_checker u_par (
    .parity_error (chk_err),
    .parity_in    (par_q),
    .data_in      (shift_q)
  );

  // Two-flop synchronizer for the asynchronous rx line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Frame state, counters, shift register and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; everything advances only on baud ticks.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    valid_d  = 1'b0;
    cnt_wrap = (cnt_q == CNT_MAX);
    if (baud_tick) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end
          end
        end
        DATA: begin
          if (cnt_wrap) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == BIT_MAX) begin
              state_d = PARITY_EN ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (cnt_wrap) begin
            par_d   = rx_s;
            state_d = STOP;
          end
        end
        STOP: begin
          if (cnt_wrap) begin
            data_d  = shift_q;
            fe_d    = ~rx_s;
            pe_d    = PARITY_EN ? chk_err : 1'b0;
            valid_d = 1'b1;
            state_d = rx_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: parity and no-parity instances
// against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

  localparam int OS   = 16;
  localparam int HALF = OS / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;
  logic [1:0] rxl = 2'b11;

  logic [1:0][7:0] o_data;
  logic [1:0] o_val, o_pe, o_fe, o_busy;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int pulses [2] = '{0, 0};
  logic [7:0] log1 [$];

  bit [1:0] m_val = '0, m_pe = '0, m_fe = '0, m_busy = '0;
  logic [1:0][7:0] m_data = '0;
  bit [1:0] s1 = 2'b11, s2 = 2'b11, rsv = 2'b11;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.OVERSAMPLE(OS), .PARITY_EN(1'b1)) dut_p (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rxl[0]),
    .rx_data(o_data[0]), .rx_valid(o_val[0]),
    .parity_error(o_pe[0]), .framing_error(o_fe[0]), .busy(o_busy[0])
  );

  uart_rx_frame_ctrl #(.OVERSAMPLE(OS), .PARITY_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rxl[1]),
    .rx_data(o_data[1]), .rx_valid(o_val[1]),
    .parity_error(o_pe[1]), .framing_error(o_fe[1]), .busy(o_busy[1])
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One clock edge as seen by receiver k: rsv is the synchronized
  // line value used at this edge.
  task automatic edge_step(int k, output bit tk, output bit r);
    @(posedge clk);
    r  = rst;
    tk = baud_tick;
    rsv[k] = s2[k];
    m_val[k] = 1'b0;
    if (r) begin
      s1[k] = 1'b1;
      s2[k] = 1'b1;
      m_data[k] = '0;
      m_pe[k] = 1'b0;
      m_fe[k] = 1'b0;
      m_busy[k] = 1'b0;
    end else begin
      s2[k] = s1[k];
      s1[k] = rxl[k];
    end
  endtask

  task automatic wait_ticks(int k, int n, output bit ab);
    bit tk, r;
    int c = 0;
    ab = 1'b0;
    while (c < n) begin
      edge_step(k, tk, r);
      if (r) begin
        ab = 1'b1;
        return;
      end
      if (tk) c++;
    end
  endtask

  task automatic model_run(int k);
    bit tk, r, ab, p, stp;
    logic [7:0] d;
    forever begin
      m_busy[k] = 1'b0;
      do edge_step(k, tk, r); while (!(tk && !r && !rsv[k]));
      m_busy[k] = 1'b1;
      wait_ticks(k, HALF, ab);
      if (ab || rsv[k]) continue;
      d = '0;
      for (int i = 0; i < 8 && !ab; i++) begin
        wait_ticks(k, OS, ab);
        d[i] = rsv[k];
      end
      if (ab) continue;
      p = 1'b0;
      if (k == 0) begin
        wait_ticks(k, OS, ab);
        if (ab) continue;
        p = rsv[k];
      end
      wait_ticks(k, OS, ab);
      if (ab) continue;
      stp = rsv[k];
      m_val[k]  = 1'b1;
      m_data[k] = d;
      m_fe[k]   = !stp;
      m_pe[k]   = (k == 0) ? ((^d) ^ p) : 1'b0;
      if (!stp) begin
        do edge_step(k, tk, r); while (!(r || (tk && rsv[k])));
      end
    end
  endtask

  initial begin
    fork
      model_run(0);
      model_run(1);
    join_none
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("valid%0d", k), 32'(o_val[k]), 32'(m_val[k]));
          chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_busy[k]));
          chk($sformatf("data%0d", k), 32'(o_data[k]), 32'(m_data[k]));
          chk($sformatf("perr%0d", k), 32'(o_pe[k]), 32'(m_pe[k]));
          chk($sformatf("ferr%0d", k), 32'(o_fe[k]), 32'(m_fe[k]));
          if (o_val[k]) begin
            pulses[k]++;
            if (k == 1) log1.push_back(o_data[1]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic ticks(int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      baud_tick = ($urandom_range(0, 2) != 0);
      if (baud_tick) c++;
    end
  endtask

  task automatic send_frame(int k, logic [7:0] b, bit p, bit sb,
                            int stop_ticks, int idle_ticks);
    rxl[k] = 1'b0;
    ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rxl[k] = b[i];
      ticks(OS);
    end
    if (k == 0) begin
      rxl[k] = p;
      ticks(OS);
    end
    rxl[k] = sb;
    ticks(stop_ticks);
    rxl[k] = 1'b1;
    ticks(idle_ticks);
  endtask

  initial begin
    int pc;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_data", 32'(o_data[k]), 32'h0);
      chk("rst_valid", 32'(o_val[k]), 32'h0);
      chk("rst_perr", 32'(o_pe[k]), 32'h0);
      chk("rst_ferr", 32'(o_fe[k]), 32'h0);
      chk("rst_busy", 32'(o_busy[k]), 32'h0);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    ticks(OS);

    send_frame(0, 8'h8F, 1'b1, 1'b1, OS, OS);
    chk("f1_pulses", 32'(pulses[0]), 32'd1);
    chk("f1_data", 32'(o_data[0]), 32'h8F);
    chk("f1_model", 32'(m_data[0]), 32'h8F);
    chk("f1_perr", 32'(o_pe[0]), 32'h0);
    chk("f1_ferr", 32'(o_fe[0]), 32'h0);

    send_frame(0, 8'h8F, 1'b0, 1'b1, OS, OS);
    chk("f2_data", 32'(o_data[0]), 32'h8F);
    chk("f2_perr", 32'(o_pe[0]), 32'h1);
    chk("f2_ferr", 32'(o_fe[0]), 32'h0);

    send_frame(0, 8'h55, 1'b0, 1'b0, 4 * OS, 0);
    chk("brk_busy", 32'(o_busy[0]), 32'h1);
    chk("brk_pulses", 32'(pulses[0]), 32'd3);
    chk("brk_data", 32'(o_data[0]), 32'h55);
    chk("brk_ferr", 32'(o_fe[0]), 32'h1);
    chk("brk_perr", 32'(o_pe[0]), 32'h0);
    ticks(OS);
    chk("brk_idle", 32'(o_busy[0]), 32'h0);
    chk("brk_once", 32'(pulses[0]), 32'd3);

    rxl[0] = 1'b0;
    ticks(4);
    rxl[0] = 1'b1;
    ticks(2 * OS);
    chk("glitch_pulses", 32'(pulses[0]), 32'd3);
    chk("glitch_busy", 32'(o_busy[0]), 32'h0);

    rxl[0] = 1'b0;
    ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rxl[0] = i[0];
      ticks(OS);
    end
    @(negedge clk);
    rst = 1'b1;
    rxl[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_data", 32'(o_data[0]), 32'h0);
    chk("abort_busy", 32'(o_busy[0]), 32'h0);
    ticks(OS);
    send_frame(0, 8'hA3, 1'b0, 1'b1, OS, OS);
    chk("abort_pulses", 32'(pulses[0]), 32'd4);
    chk("a3_data", 32'(o_data[0]), 32'hA3);
    chk("a3_perr", 32'(o_pe[0]), 32'h0);
    chk("a3_ferr", 32'(o_fe[0]), 32'h0);

    send_frame(1, 8'h00, 1'b0, 1'b1, OS, 0);
    send_frame(1, 8'hFF, 1'b0, 1'b1, OS, 2 * OS);
    chk("b2b_pulses", 32'(pulses[1]), 32'd2);
    chk("b2b_first", 32'(log1[0]), 32'h00);
    chk("b2b_second", 32'(log1[1]), 32'hFF);
    chk("b2b_perr", 32'(o_pe[1]), 32'h0);

    pc = pulses[0] + pulses[1];
    for (int n = 0; n < 40; n++) begin
      int k;
      bit sb;
      k = int'($urandom_range(0, 1));
      sb = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) begin
        rxl[k] = 1'b0;
        ticks(int'($urandom_range(1, HALF - 2)));
        rxl[k] = 1'b1;
        ticks(OS);
      end else begin
        send_frame(k, 8'($urandom), 1'($urandom), sb,
                   sb ? OS : int'($urandom_range(OS, 3 * OS)),
                   int'($urandom_range(1, OS)));
        pc++;
      end
    end
    ticks(2 * OS);
    chk("rand_pulses", 32'(pulses[0] + pulses[1]), 32'(pc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
